// File: rtl/xadac_pkg.sv
// Shared types and default sizes for the XADAC vector write-back path.
// The write-back request struct is sized from the package localparams, so a
// top-level instance must keep its width parameters equal to these defaults.
package xadac_pkg;

    localparam int XADAC_VREG_W        = 128;
    localparam int XADAC_ADDR_W        = 5;
    localparam int XADAC_BE_W          = XADAC_VREG_W / 8;
    localparam int XADAC_WB_SRC_CNT    = 3;
    localparam int XADAC_WB_FIFO_DEPTH = 2;

    // One pending VRF write: destination register, data and byte enables.
    typedef struct packed {
        logic [XADAC_ADDR_W-1:0] addr;
        logic [XADAC_VREG_W-1:0] data;
        logic [XADAC_BE_W-1:0]   be;
    } xadac_wb_req_t;

    // Index width for n items. It never drops below 1 bit, so a single-entry
    // select still gets a legal vector.
    function automatic int xadac_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xadac_wb_fifo.sv
// Small synchronous FIFO of write-back requests. It has one slot per entry and
// a valid bit per slot. Every slot and its valid bit are exported so that the
// parent can build the pending-register mask from registered state only.
// A push is refused when the FIFO is full, even if a pop happens in the same
// cycle. A pop is refused when the FIFO is empty. Flush clears everything at
// the next edge and wins over any push or pop in that cycle.
module xadac_wb_fifo
    import xadac_pkg::*;
#(
    parameter int DEPTH = XADAC_WB_FIFO_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      async_rst_ni,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  xadac_wb_req_t             push_data_i,
    input  logic                      pop_i,
    output xadac_wb_req_t             head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [DEPTH-1:0]          ent_vld_o,
    output xadac_wb_req_t [DEPTH-1:0] ent_o
);

    localparam int PTR_W = xadac_idx_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DEPTH-1:0]          vld_q, vld_d;
    xadac_wb_req_t [DEPTH-1:0] mem_q;
    logic                      do_push;
    logic                      do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Next-state pointers, occupancy and slot valids. DEPTH is a power of two,
    // so the pointers wrap by plain overflow.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            vld_d  = '0;
        end else begin
            if (do_pop) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + 1'b1;
            end
            if (do_push) begin
                vld_d[tail_q] = 1'b1;
                tail_d        = tail_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register. An asynchronous reset empties the FIFO.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    // Payload storage. It needs no reset because the valid bits qualify
    // every slot.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_o    = mem_q[head_q];
    assign ent_o     = mem_q;
    assign ent_vld_o = vld_q;

endmodule

// File: rtl/xadac_vrf_wb_arb.sv
// Write-back arbiter in front of the vector register file. Each producer has
// its own small FIFO. A round-robin arbiter picks one non-empty FIFO per cycle
// and drives the single VRF write port from that FIFO's registered head.
// pend_o marks every register that still has a buffered write, so operand
// issue can hold back dependent reads.
//
// Handshake, per source s:
//   - A request transfers at a rising edge when src_valid_i[s] and
//     src_ready_o[s] are both high.
//   - While valid is high and ready is low, the producer keeps its payload
//     stable.
//   - src_ready_o[s] depends only on the registered full flag and flush_i. A
//     full FIFO never accepts a request, even if it pops in the same cycle.
//   - The VRF port has no ready. wr_we_o high means the write commits at the
//     next rising edge.
module xadac_vrf_wb_arb
    import xadac_pkg::*;
#(
    parameter int VREG_W     = XADAC_VREG_W,
    parameter int ADDR_W     = XADAC_ADDR_W,
    parameter int SRC_CNT    = XADAC_WB_SRC_CNT,
    parameter int FIFO_DEPTH = XADAC_WB_FIFO_DEPTH
) (
    input  logic                            clk_i,
    input  logic                            async_rst_ni,
    input  logic                            flush_i,
    input  logic [SRC_CNT-1:0]              src_valid_i,
    output logic [SRC_CNT-1:0]              src_ready_o,
    input  logic [SRC_CNT*ADDR_W-1:0]       src_addr_i,
    input  logic [SRC_CNT*VREG_W-1:0]       src_data_i,
    input  logic [SRC_CNT*(VREG_W/8)-1:0]   src_be_i,
    output logic [ADDR_W-1:0]               wr_addr_o,
    output logic [VREG_W-1:0]               wr_data_o,
    output logic [VREG_W/8-1:0]             wr_be_o,
    output logic                            wr_we_o,
    output logic [xadac_idx_w(SRC_CNT)-1:0] wr_src_o,
    output logic [2**ADDR_W-1:0]            pend_o
);

    localparam int BE_W  = VREG_W / 8;
    localparam int SRC_W = xadac_idx_w(SRC_CNT);

    xadac_wb_req_t [SRC_CNT-1:0]                 push_req;
    xadac_wb_req_t [SRC_CNT-1:0]                 head;
    xadac_wb_req_t [SRC_CNT-1:0][FIFO_DEPTH-1:0] ent;
    logic [SRC_CNT-1:0][FIFO_DEPTH-1:0]          ent_vld;
    logic [SRC_CNT-1:0]                          full;
    logic [SRC_CNT-1:0]                          empty;
    logic [SRC_CNT-1:0]                          push;
    logic [SRC_CNT-1:0]                          pop;
    logic [SRC_W-1:0]                            rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]                            gnt_idx;
    logic                                        gnt_vld;

    assign src_ready_o = ~full & {SRC_CNT{~flush_i}};
    assign push        = src_valid_i & src_ready_o;

    for (genvar g = 0; g < SRC_CNT; g++) begin : g_src
        assign push_req[g].addr = src_addr_i[g*ADDR_W +: ADDR_W];
        assign push_req[g].data = src_data_i[g*VREG_W +: VREG_W];
        assign push_req[g].be   = src_be_i[g*BE_W +: BE_W];
        assign pop[g]           = gnt_vld & (gnt_idx == SRC_W'(g));

        xadac_wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i        (clk_i),
            .async_rst_ni (async_rst_ni),
            .flush_i      (flush_i),
            .push_i       (push[g]),
            .push_data_i  (push_req[g]),
            .pop_i        (pop[g]),
            .head_o       (head[g]),
            .full_o       (full[g]),
            .empty_o      (empty[g]),
            .ent_vld_o    (ent_vld[g]),
            .ent_o        (ent[g])
        );
    end

    // Round-robin grant: the first non-empty source at or after rr_ptr_q.
    // The loop walks the offsets backwards, so the last hit, which is the
    // smallest offset, wins. No grant is given during a flush.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = SRC_CNT - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= SRC_CNT) begin
                idx = idx - SRC_CNT;
            end
            if (!empty[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SRC_W'(idx);
            end
        end
        if (flush_i) begin
            gnt_vld = 1'b0;
        end
    end

    // The pointer moves one past the granted source, returns to 0 on a flush,
    // and holds when nothing is granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == SRC_W'(SRC_CNT - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // VRF port mux. It is driven only from registered FIFO heads and the
    // grant, and all fields are zero when no write is issued.
    always_comb begin
        wr_we_o   = gnt_vld;
        wr_addr_o = '0;
        wr_data_o = '0;
        wr_be_o   = '0;
        wr_src_o  = '0;
        if (gnt_vld) begin
            wr_addr_o = head[gnt_idx].addr;
            wr_data_o = head[gnt_idx].data;
            wr_be_o   = head[gnt_idx].be;
            wr_src_o  = gnt_idx;
        end
    end

    // Pending mask: the OR of onehot(addr) over every valid buffered entry.
    // A bit drops the cycle after its write has committed.
    always_comb begin
        pend_o = '0;
        for (int s = 0; s < SRC_CNT; s++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (ent_vld[s][e]) begin
                    pend_o[ent[s][e].addr] = 1'b1;
                end
            end
        end
    end

endmodule
